// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: synchronises and filters A/B/Z, decodes Gray-code
// steps into registered enable/up_down pulses, flags illegal jumps and turns the index edge into a preset.
module quad_step_decoder #(
  parameter int          FILTER_LEN  = 4,
  parameter logic [3:0]  INDEX_VALUE = 4'b0000,
  parameter int          ERR_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             z_in,
  input  logic             index_en,
  input  logic             err_clr,
  output logic             enable,
  output logic             up_down,
  output logic             set,
  output logic [3:0]       set_value,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [3:0] FLEN = 4'(FILTER_LEN);

  logic [2:0] sync1_q, sync2_q;
  logic [1:0] warm_q;
  logic [1:0] sync_ab;
  logic       sync_z;

  logic [1:0] ab_filt_q, ab_filt_d, ab_cand_q, ab_cand_d;
  logic [3:0] ab_cnt_q, ab_cnt_d;
  logic       ab_base_q, ab_base_d, ab_acc;

  logic       z_filt_q, z_filt_d, z_cand_q, z_cand_d;
  logic [3:0] z_cnt_q, z_cnt_d;
  logic       z_base_q, z_base_d, z_acc;

  logic ev_up_q, ev_up_d, ev_dn_q, ev_dn_d, ev_ill_q, ev_ill_d, ev_idx_q, ev_idx_d;

  logic             enable_q, up_down_q, set_q, err_q;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  function automatic logic [1:0] next_up(input logic [1:0] s);
    case (s)
      2'b00:   next_up = 2'b10;
      2'b10:   next_up = 2'b11;
      2'b11:   next_up = 2'b01;
      default: next_up = 2'b00;
    endcase
  endfunction

  assign sync_ab = sync2_q[2:1];
  assign sync_z  = sync2_q[0];

  // Until the baseline is valid every synced value is treated as "new", so the
  // first stable value after reset is accepted silently; warm_q keeps the reset
  // contents of the synchroniser from being mistaken for that baseline.
  always_comb begin
    ab_cand_d = ab_cand_q;
    ab_cnt_d  = ab_cnt_q;
    ab_filt_d = ab_filt_q;
    ab_base_d = ab_base_q;
    ab_acc    = 1'b0;
    if (!warm_q[1] || (ab_base_q && sync_ab == ab_filt_q)) begin
      ab_cnt_d = 4'd0;
    end else if (sync_ab == ab_cand_q) begin
      if (ab_cnt_q == FLEN) begin
        ab_acc    = 1'b1;
        ab_filt_d = ab_cand_q;
        ab_cnt_d  = 4'd0;
        ab_base_d = 1'b1;
      end else begin
        ab_cnt_d = ab_cnt_q + 4'd1;
      end
    end else begin
      ab_cand_d = sync_ab;
      ab_cnt_d  = 4'd1;
    end
  end

  always_comb begin
    z_cand_d = z_cand_q;
    z_cnt_d  = z_cnt_q;
    z_filt_d = z_filt_q;
    z_base_d = z_base_q;
    z_acc    = 1'b0;
    if (!warm_q[1] || (z_base_q && sync_z == z_filt_q)) begin
      z_cnt_d = 4'd0;
    end else if (sync_z == z_cand_q) begin
      if (z_cnt_q == FLEN) begin
        z_acc    = 1'b1;
        z_filt_d = z_cand_q;
        z_cnt_d  = 4'd0;
        z_base_d = 1'b1;
      end else begin
        z_cnt_d = z_cnt_q + 4'd1;
      end
    end else begin
      z_cand_d = sync_z;
      z_cnt_d  = 4'd1;
    end
  end

  // Decode compares the outgoing filtered value with the one being accepted.
  always_comb begin
    ev_up_d  = ab_acc && ab_base_q && (ab_cand_q == next_up(ab_filt_q));
    ev_dn_d  = ab_acc && ab_base_q && (ab_filt_q == next_up(ab_cand_q));
    ev_ill_d = ab_acc && ab_base_q && ((ab_filt_q ^ ab_cand_q) == 2'b11);
    ev_idx_d = z_acc && z_base_q && index_en && z_cand_q && !z_filt_q;
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (ev_ill_q && err_cnt_q != {ERR_W{1'b1}}) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      warm_q    <= '0;
      ab_filt_q <= '0;
      ab_cand_q <= '0;
      ab_cnt_q  <= '0;
      ab_base_q <= 1'b0;
      z_filt_q  <= 1'b0;
      z_cand_q  <= 1'b0;
      z_cnt_q   <= '0;
      z_base_q  <= 1'b0;
      ev_up_q   <= 1'b0;
      ev_dn_q   <= 1'b0;
      ev_ill_q  <= 1'b0;
      ev_idx_q  <= 1'b0;
      enable_q  <= 1'b0;
      up_down_q <= 1'b0;
      set_q     <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      sync1_q   <= {a_in, b_in, z_in};
      sync2_q   <= sync1_q;
      warm_q    <= {warm_q[0], 1'b1};
      ab_filt_q <= ab_filt_d;
      ab_cand_q <= ab_cand_d;
      ab_cnt_q  <= ab_cnt_d;
      ab_base_q <= ab_base_d;
      z_filt_q  <= z_filt_d;
      z_cand_q  <= z_cand_d;
      z_cnt_q   <= z_cnt_d;
      z_base_q  <= z_base_d;
      ev_up_q   <= ev_up_d;
      ev_dn_q   <= ev_dn_d;
      ev_ill_q  <= ev_ill_d;
      ev_idx_q  <= ev_idx_d;
      // A preset in the same cycle wins over the step; direction still tracks it.
      enable_q  <= (ev_up_q || ev_dn_q) && !ev_idx_q;
      if (ev_up_q || ev_dn_q) up_down_q <= ev_up_q;
      set_q     <= ev_idx_q;
      err_q     <= ev_ill_q;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign enable    = enable_q;
  assign up_down   = up_down_q;
  assign set       = set_q;
  assign set_value = INDEX_VALUE;
  assign err       = err_q;
  assign err_count = err_cnt_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: drivers push expected output events into a
// queue, a negedge monitor pops and compares whenever enable/err/set fires.
module tb_quad_step_decoder;

  localparam int FL = 4;
  localparam int W  = 28;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_in = 1'b0, b_in = 1'b0, z_in = 1'b0;
  logic       index_en = 1'b0, err_clr = 1'b0;
  logic       enable, up_down, set, err;
  logic [3:0] set_value;
  logic [7:0] err_count;

  quad_step_decoder #(.FILTER_LEN(FL), .INDEX_VALUE(4'b0000), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .z_in(z_in),
    .index_en(index_en), .err_clr(err_clr), .enable(enable), .up_down(up_down),
    .set(set), .set_value(set_value), .err(err), .err_count(err_count)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_NONE, EV_UP, EV_DN, EV_ERR, EV_SETUP, EV_ERRCLR} ev_e;

  logic [W-1:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         pos = 0;
  logic       exp_dir = 1'b0;
  logic [7:0] exp_ec = 8'd0;

  function automatic logic [W-1:0] pack(input int cy, input logic s, input logic e,
                                        input logic d, input logic er, input logic [7:0] ec);
    logic [15:0] c16;
    c16 = 16'(cy);
    pack = {c16, s, e, d, er, ec};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // Output is expected FL+4 tb cycles after the drive point (FL+3 DUT edges after first sample).
  task automatic push_ev(input ev_e k, input int c);
    case (k)
      EV_UP:     begin exp_dir = 1'b1; exp_q.push_back(pack(c + FL + 4, 1'b0, 1'b1, 1'b1, 1'b0, exp_ec)); end
      EV_DN:     begin exp_dir = 1'b0; exp_q.push_back(pack(c + FL + 4, 1'b0, 1'b1, 1'b0, 1'b0, exp_ec)); end
      EV_ERR:    begin
        if (exp_ec != 8'hff) exp_ec = exp_ec + 8'd1;
        exp_q.push_back(pack(c + FL + 4, 1'b0, 1'b0, exp_dir, 1'b1, exp_ec));
      end
      EV_SETUP:  begin exp_dir = 1'b1; exp_q.push_back(pack(c + FL + 4, 1'b1, 1'b0, 1'b1, 1'b0, exp_ec)); end
      EV_ERRCLR: begin exp_ec = 8'd0; exp_q.push_back(pack(c + FL + 4, 1'b0, 1'b0, exp_dir, 1'b1, 8'd0)); end
      default: ;
    endcase
  endtask

  // driver: one step occupies 10 clock cycles
  task automatic apply(input logic [1:0] ab, input logic z, input logic ien, input ev_e k);
    int c;
    @(posedge clk); #1;
    a_in = ab[1]; b_in = ab[0]; z_in = z; index_en = ien;
    c = cyc;
    push_ev(k, c);
    if (k == EV_ERRCLR) begin
      repeat (7) @(posedge clk);
      #1 err_clr = 1'b1;
      @(posedge clk);
      #1 err_clr = 1'b0;
      @(posedge clk);
    end else begin
      repeat (9) @(posedge clk);
    end
  endtask

  task automatic glitch_a();
    @(posedge clk); #1 a_in = ~a_in;
    repeat (2) @(posedge clk);
    #1 a_in = ~a_in;
    repeat (10) @(posedge clk);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [W-1:0] got, expv;
    if (rst_n && (enable || err || set)) begin
      checks++;
      got = pack(cyc, set, enable, up_down, err, err_count);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: got cyc=%0d set=%0b en=%0b dir=%0b err=%0b cnt=%0d, expected no pulse",
                 cyc, set, enable, up_down, err, err_count);
      end else begin
        expv = exp_q.pop_front();
        if (got !== expv) begin
          errors++;
          $display("FAIL event: got cyc=%0d set=%0b en=%0b dir=%0b err=%0b cnt=%0d, expected cyc=%0d set=%0b en=%0b dir=%0b err=%0b cnt=%0d",
                   got[27:12], got[11], got[10], got[9], got[8], got[7:0],
                   expv[27:12], expv[11], expv[10], expv[9], expv[8], expv[7:0]);
        end
      end
      if (set) begin
        checks++;
        if (set_value !== 4'b0000) begin
          errors++;
          $display("FAIL set_value: got %0h, expected 0", set_value);
        end
      end
      if (enable) pos = pos + (up_down ? 1 : -1);
      if (set) pos = int'(set_value);
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_enable", 32'(enable), 32'd0);
    check("rst_up_down", 32'(up_down), 32'd0);
    check("rst_set", 32'(set), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_set_value", 32'(set_value), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("idle_err_count", 32'(err_count), 32'd0);

    // up rotation
    apply(2'b10, 1'b0, 1'b0, EV_UP);
    apply(2'b11, 1'b0, 1'b0, EV_UP);
    apply(2'b01, 1'b0, 1'b0, EV_UP);
    apply(2'b00, 1'b0, 1'b0, EV_UP);
    @(negedge clk);
    check("pos_after_up", 32'(pos), 32'd4);
    check("dir_after_up", 32'(up_down), 32'd1);

    // down rotation with a short glitch on A while at 11
    apply(2'b01, 1'b0, 1'b0, EV_DN);
    apply(2'b11, 1'b0, 1'b0, EV_DN);
    glitch_a();
    apply(2'b10, 1'b0, 1'b0, EV_DN);
    apply(2'b00, 1'b0, 1'b0, EV_DN);
    @(negedge clk);
    check("pos_after_down", 32'(pos), 32'd0);
    check("dir_after_down", 32'(up_down), 32'd0);

    // illegal jumps and saturation
    apply(2'b11, 1'b0, 1'b0, EV_ERR);
    @(negedge clk);
    check("err_count_one", 32'(err_count), 32'd1);
    check("dir_after_err", 32'(up_down), 32'd0);
    for (int i = 1; i < 300; i++) begin
      apply((i % 2 == 1) ? 2'b00 : 2'b11, 1'b0, 1'b0, EV_ERR);
    end
    @(negedge clk);
    check("err_count_sat", 32'(err_count), 32'd255);
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    exp_ec = 8'd0;
    @(negedge clk);
    check("err_count_clr", 32'(err_count), 32'd0);
    apply(2'b11, 1'b0, 1'b0, EV_ERRCLR);
    apply(2'b01, 1'b0, 1'b0, EV_UP);
    apply(2'b00, 1'b0, 1'b0, EV_UP);

    // index
    apply(2'b10, 1'b1, 1'b1, EV_SETUP);
    apply(2'b10, 1'b0, 1'b1, EV_NONE);
    apply(2'b11, 1'b1, 1'b0, EV_UP);
    apply(2'b11, 1'b0, 1'b0, EV_NONE);
    @(negedge clk);
    check("pos_after_index", 32'(pos), 32'd1);

    // reset mid-rotation at AB=11
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_up_down", 32'(up_down), 32'd0);
    check("midrst_enable", 32'(enable), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_dir = 1'b0;
    repeat (14) @(posedge clk);
    apply(2'b01, 1'b0, 1'b0, EV_UP);

    repeat (5) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
